// File: rtl/flash_responder.sv
// Responder model of a 16-bit parallel NOR flash: decodes CUI writes
// and serves array/status reads from an internal word memory.
module flash_responder #(
  parameter int FLASH_ADDR_SIZE = 22,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int BLOCK_LOG2      = 6,
  parameter int PROG_CYCLES     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLASH_ADDR_SIZE:0] flash_addr,
  inout  wire  [15:0]              flash_data,
  input  logic [7:0]               flash_ctl,
  output logic                     dev_busy
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int CW    = $clog2(PROG_CYCLES + 1);
  localparam int BW    = MEM_ADDR_WIDTH - BLOCK_LOG2;

  localparam logic [2:0] S_READY = 3'd0;
  localparam logic [2:0] S_PSET  = 3'd1;
  localparam logic [2:0] S_PBUSY = 3'd2;
  localparam logic [2:0] S_ESET  = 3'd3;
  localparam logic [2:0] S_EBUSY = 3'd4;

  localparam logic M_ARRAY  = 1'b0;
  localparam logic M_STATUS = 1'b1;

  logic ce_n, oe_n, rp_n, we_n;
  assign ce_n = flash_ctl[6];
  assign oe_n = flash_ctl[3];
  assign rp_n = flash_ctl[2];
  assign we_n = flash_ctl[0];

  logic unused_ok;
  assign unused_ok = ^{flash_ctl[7], flash_ctl[5:4], flash_ctl[1],
                       flash_addr[FLASH_ADDR_SIZE:MEM_ADDR_WIDTH+1],
                       flash_addr[0]};

  logic [MEM_ADDR_WIDTH-1:0] idx;
  assign idx = flash_addr[MEM_ADDR_WIDTH:1];

  // Content survives reset; power-up image is fully erased.
  logic [15:0] mem_q [DEPTH] = '{default: 16'hFFFF};

  logic [2:0]                state_q, state_d;
  logic                      mode_q, mode_d;
  logic                      rdy_q, rdy_d;
  logic                      erre_q, erre_d;
  logic                      errp_q, errp_d;
  logic                      we_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BLOCK_LOG2-1:0]     swp_q, swp_d;
  logic [BW-1:0]             blk_q, blk_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]               data_q, data_d;
  logic [15:0]               rd_q;

  logic        run;
  logic        commit;
  logic [15:0] wdat;
  logic [15:0] sr;
  logic        prog_we;
  logic        erase_we;

  assign run    = rst_n && rp_n;
  assign commit = !we_q && we_n && !ce_n;
  assign wdat   = flash_data;
  assign sr     = {8'h00, rdy_q, 1'b0, erre_q, errp_q, 4'h0};

  assign dev_busy = !rdy_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rdy_d    = rdy_q;
    erre_d   = erre_q;
    errp_d   = errp_q;
    cnt_d    = cnt_q;
    swp_d    = swp_q;
    blk_d    = blk_q;
    addr_d   = addr_q;
    data_d   = data_q;
    prog_we  = 1'b0;
    erase_we = 1'b0;
    unique case (state_q)
      S_READY: begin
        if (commit && wdat[15:8] == 8'h00) begin
          unique case (wdat[7:0])
            8'hFF: mode_d = M_ARRAY;
            8'h70: mode_d = M_STATUS;
            8'h50: begin
              erre_d = 1'b0;
              errp_d = 1'b0;
            end
            8'h40, 8'h10: begin
              state_d = S_PSET;
              mode_d  = M_STATUS;
            end
            8'h20: begin
              state_d = S_ESET;
              mode_d  = M_STATUS;
            end
            default: ;
          endcase
        end
      end
      S_PSET: begin
        if (commit) begin
          addr_d  = idx;
          data_d  = wdat;
          state_d = S_PBUSY;
          rdy_d   = 1'b0;
          cnt_d   = CW'(PROG_CYCLES);
        end
      end
      S_PBUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prog_we = run;
          rdy_d   = 1'b1;
          state_d = S_READY;
        end
      end
      S_ESET: begin
        if (commit) begin
          if (wdat == 16'h00D0) begin
            state_d = S_EBUSY;
            blk_d   = idx[MEM_ADDR_WIDTH-1:BLOCK_LOG2];
            swp_d   = '0;
            rdy_d   = 1'b0;
          end else begin
            erre_d  = 1'b1;
            errp_d  = 1'b1;
            state_d = S_READY;
          end
        end
      end
      S_EBUSY: begin
        erase_we = run;
        swp_d    = swp_q + BLOCK_LOG2'(1);
        if (swp_q == '1) begin
          rdy_d   = 1'b1;
          state_d = S_READY;
          swp_d   = '0;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  // rp_n acts like rst_n on the controller only.
  always_ff @(posedge clk) begin
    if (!run) begin
      state_q <= S_READY;
      mode_q  <= M_ARRAY;
      rdy_q   <= 1'b1;
      erre_q  <= 1'b0;
      errp_q  <= 1'b0;
      we_q    <= 1'b1;
      cnt_q   <= '0;
      swp_q   <= '0;
      blk_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rdy_q   <= rdy_d;
      erre_q  <= erre_d;
      errp_q  <= errp_d;
      we_q    <= we_n;
      cnt_q   <= cnt_d;
      swp_q   <= swp_d;
      blk_q   <= blk_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[addr_q] <= mem_q[addr_q] & data_q;
    end else if (erase_we) begin
      mem_q[{blk_q, swp_q}] <= 16'hFFFF;
    end
    rd_q <= (mode_q == M_STATUS) ? sr : mem_q[idx];
  end

  assign flash_data = (!ce_n && !oe_n) ? rd_q : 16'hzzzz;

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: vector table plus hand sequences
// for busy timing, erase abort via rp_n and bus release.
module tb_flash_responder;

  localparam int FAS = 22;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_POLL = 2;

  typedef struct {
    int          kind;
    logic [FAS:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [FAS:0] addr;
  logic         ce_n, oe_n, rp_n, we_n;
  logic [7:0]   ctl;
  wire  [15:0]  fdata;
  logic [15:0]  drv_data;
  logic         drv_en;
  logic         busy;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  assign ctl   = {1'b1, ce_n, 1'b1, 1'b1, oe_n, rp_n, 1'b1, we_n};
  assign fdata = drv_en ? drv_data : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pd
    pulldown (fdata[g]);
  end

  flash_responder #(
    .FLASH_ADDR_SIZE(FAS),
    .MEM_ADDR_WIDTH (10),
    .BLOCK_LOG2     (6),
    .PROG_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flash_addr(addr),
    .flash_data(fdata),
    .flash_ctl (ctl),
    .dev_busy  (busy)
  );

  function automatic logic [FAS:0] B(input int w);
    return (FAS+1)'(w * 2);
  endfunction

  function automatic vec_t mk(input int k, input int w,
                              input logic [15:0] d,
                              input logic [15:0] e);
    vec_t v;
    v.kind = k;
    v.a    = B(w);
    v.d    = d;
    v.exp  = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [FAS:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; drv_data = d; drv_en = 1'b1; oe_n = 1'b1; we_n = 1'b0;
    @(negedge clk);
    we_n = 1'b1;
    @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic rd(input logic [FAS:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; oe_n = 1'b0;
    @(negedge clk);
    d = fdata;
    oe_n = 1'b1;
  endtask

  task automatic poll(output logic [15:0] s);
    s = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      rd(B(0), s);
      if (s[7]) break;
    end
  endtask

  task automatic prog(input int w, input logic [15:0] d);
    logic [15:0] s;
    wr(B(w), 16'h0040);
    wr(B(w), d);
    poll(s);
    check($sformatf("prog_w%0d", w), s, 16'h0080);
  endtask

  vec_t        tv[$];
  logic [15:0] r;
  int          n;

  initial begin
    rst_n = 1'b0; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b1; rp_n = 1'b1;
    drv_en = 1'b0; drv_data = 16'h0000; addr = '0;

    tv.push_back(mk(K_RD,   5,    16'h0000, 16'hFFFF));
    tv.push_back(mk(K_WR,   5,    16'h0040, 16'h0000));
    tv.push_back(mk(K_WR,   5,    16'h1234, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   0,    16'h00FF, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h1234));
    tv.push_back(mk(K_WR,   5,    16'h0040, 16'h0000));
    tv.push_back(mk(K_WR,   5,    16'hFF00, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   0,    16'h00FF, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h1200));
    tv.push_back(mk(K_WR,   0,    16'h0070, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   64,   16'h0040, 16'h0000));
    tv.push_back(mk(K_WR,   64,   16'h0A0A, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   127,  16'h0040, 16'h0000));
    tv.push_back(mk(K_WR,   127,  16'h5555, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   63,   16'h0040, 16'h0000));
    tv.push_back(mk(K_WR,   63,   16'h1111, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   128,  16'h0010, 16'h0000));
    tv.push_back(mk(K_WR,   128,  16'h2222, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   0,    16'h00FF, 16'h0000));
    tv.push_back(mk(K_RD,   64,   16'h0000, 16'h0A0A));
    tv.push_back(mk(K_RD,   127,  16'h0000, 16'h5555));
    tv.push_back(mk(K_WR,   70,   16'h0020, 16'h0000));
    tv.push_back(mk(K_WR,   70,   16'h00D0, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   0,    16'h00FF, 16'h0000));
    tv.push_back(mk(K_RD,   64,   16'h0000, 16'hFFFF));
    tv.push_back(mk(K_RD,   100,  16'h0000, 16'hFFFF));
    tv.push_back(mk(K_RD,   127,  16'h0000, 16'hFFFF));
    tv.push_back(mk(K_RD,   63,   16'h0000, 16'h1111));
    tv.push_back(mk(K_RD,   128,  16'h0000, 16'h2222));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h1200));
    tv.push_back(mk(K_WR,   0,    16'h0020, 16'h0000));
    tv.push_back(mk(K_WR,   0,    16'h00FF, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h00B0));
    tv.push_back(mk(K_WR,   0,    16'h01FF, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h00B0));
    tv.push_back(mk(K_WR,   0,    16'h0050, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   1029, 16'h0010, 16'h0000));
    tv.push_back(mk(K_WR,   1029, 16'h1030, 16'h0000));
    tv.push_back(mk(K_POLL, 0,    16'h0000, 16'h0080));
    tv.push_back(mk(K_WR,   0,    16'h00FF, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h1000));
    tv.push_back(mk(K_WR,   0,    16'h0090, 16'h0000));
    tv.push_back(mk(K_RD,   5,    16'h0000, 16'h1000));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {15'h0, busy}, 16'h0000);

    foreach (tv[i]) begin
      unique case (tv[i].kind)
        K_WR: wr(tv[i].a, tv[i].d);
        K_RD: begin
          rd(tv[i].a, r);
          check($sformatf("vec%0d_rd", i), r, tv[i].exp);
        end
        default: begin
          poll(r);
          check($sformatf("vec%0d_poll", i), r, tv[i].exp);
        end
      endcase
    end

    // bus released whenever oe_n or ce_n is high
    @(negedge clk);
    addr = B(5); oe_n = 1'b0;
    @(negedge clk);
    check("drive_on", fdata, 16'h1000);
    oe_n = 1'b1;
    #1 check("release_oe", fdata, 16'h0000);
    oe_n = 1'b0; ce_n = 1'b1;
    #1 check("release_ce", fdata, 16'h0000);
    ce_n = 1'b0; oe_n = 1'b1;

    // program busy window length
    wr(B(200), 16'h0040);
    check("prog_pre_busy", {15'h0, busy}, 16'h0000);
    wr(B(200), 16'hABCD);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("prog_busy_len", 16'(n), 16'd8);
    wr(B(0), 16'h00FF);
    rd(B(200), r);
    check("prog_word200", r, 16'hABCD);

    // erase busy window, with an ignored commit inside it
    wr(B(300), 16'h0020);
    wr(B(300), 16'h00D0);
    wr(B(0), 16'h00FF);
    n = 3;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("erase_busy_len", 16'(n), 16'd64);
    rd(B(300), r);
    check("erase_ign_cmd", r, 16'h0080);

    // rp_n abort partway through an erase
    prog(320, 16'h0000);
    prog(330, 16'h0000);
    prog(335, 16'h0000);
    prog(383, 16'h0000);
    wr(B(330), 16'h0020);
    wr(B(330), 16'h00D0);
    repeat (10) @(negedge clk);
    rp_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {15'h0, busy}, 16'h0000);
    rp_n = 1'b1;
    rd(B(320), r);
    check("abort_w320", r, 16'hFFFF);
    rd(B(329), r);
    check("abort_w329", r, 16'hFFFF);
    rd(B(330), r);
    check("abort_w330", r, 16'h0000);
    rd(B(335), r);
    check("abort_w335", r, 16'h0000);
    rd(B(383), r);
    check("abort_w383", r, 16'h0000);
    wr(B(0), 16'h0070);
    rd(B(0), r);
    check("abort_sr", r, 16'h0080);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/flash_responder.md
# flash_responder

Synthesizable responder model of the 16-bit parallel NOR flash that `flash_driver` controls. It sits on the far side of the flash pins (`flash_addr`, `flash_data`, `flash_ctl`), decodes the command-user-interface writes (read array, read status, clear status, program, block erase), and serves array and status reads from an internal word memory. It is used in simulation benches and in on-FPGA loopback builds in place of the physical chip.

## Interface
- `FLASH_ADDR_SIZE`, 22, word-address width; `flash_addr` is one bit wider (byte address, bit 0 ignored)
- `MEM_ADDR_WIDTH`, 10, implemented words = 2^MEM_ADDR_WIDTH; word index = `flash_addr[MEM_ADDR_WIDTH:1]`, higher bits ignored (aliasing)
- `BLOCK_LOG2`, 6, erase block = 2^BLOCK_LOG2 words, aligned
- `PROG_CYCLES`, 8, busy cycles per word program (>= 1)

- `clk` input 1 system clock, same clock as the driver
- `rst_n` input 1 synchronous active-low reset
- `flash_addr` input FLASH_ADDR_SIZE+1 byte address from driver
- `flash_data` inout 16 data bus; responder drives only during a read
- `flash_ctl` input 8 {byte, ce_n, ce1, ce2, oe_n, rp_n, vpen, we_n} (bit 7..0); byte, ce1, ce2, vpen ignored
- `dev_busy` output 1 high while a program or erase is executing (= ~SR[7])

## Operation
- Bus write commit: at each posedge, `we_q <= we_n`; commit when `we_q==0 && we_n==1 && ce_n==0`. Committed data = `flash_data` and address = `flash_addr` sampled at that same edge.
- Read mode register: ARRAY or STATUS. Status register SR: bit 7 ready, bit 5 erase/sequence error, bit 4 program/sequence error; other bits 0.
- Controller states:
  - READY: commit 16'h00FF -> mode ARRAY; 16'h0070 -> mode STATUS; 16'h0050 -> SR[5:4] cleared; 16'h0040 or 16'h0010 -> PROG_SETUP, mode STATUS; 16'h0020 -> ERASE_SETUP, mode STATUS; any other value ignored. Only data bits [7:0] are decoded; bits [15:8] must be 0, else ignored.
  - PROG_SETUP: next commit latches address/data -> PROG_BUSY, SR[7]=0, counter = PROG_CYCLES.
  - PROG_BUSY: counter decrements each cycle; at 1, `mem[idx] <= mem[idx] & data` (bits only clear), SR[7]=1 -> READY.
  - ERASE_SETUP: next commit: data 16'h00D0 -> ERASE_BUSY, block base latched, sweep index 0, SR[7]=0. Any other data -> SR[5]=SR[4]=1 -> READY, no erase.
  - ERASE_BUSY: one word per cycle set to 16'hFFFF, sweep index 0..2^BLOCK_LOG2-1; after the last word SR[7]=1 -> READY.
- Commits during PROG_BUSY/ERASE_BUSY are ignored; mode stays STATUS.
- `rp_n==0` sampled: same effect as `rst_n` on controller state (any operation aborts; partially erased block stays partial). Memory is untouched.
- Memory content is never affected by reset; power-up content is all 16'hFFFF.
- Read path: `rd_q` is registered every cycle = SR (mode STATUS) or `mem[idx]` of current `flash_addr` (mode ARRAY). `flash_data = (!ce_n && !oe_n) ? rd_q : 16'hzzzz`, combinational in ce_n/oe_n so data is valid in the same cycle OE falls.

## Timing
- Reset (`rst_n==0` at posedge): state READY, mode ARRAY, SR = 16'h0080, `we_q`=1, counters 0, `dev_busy`=0, `flash_data` released whenever oe_n or ce_n is high.
- Array read latency: 1 cycle from `flash_addr` change to new word in `rd_q`; status read reflects SR updated in the previous cycle.
- Program: `dev_busy` rises the cycle after the data commit, stays high exactly PROG_CYCLES cycles; memory updated on the edge where `dev_busy` falls.
- Erase: `dev_busy` high exactly 2^BLOCK_LOG2 cycles after the confirm commit.
- Responder never drives the bus while oe_n is high, so the driver's idle bus drive never contends.
- Simultaneous commit and operation completion in the same cycle: commit ignored (still busy at that edge).

## Test plan
- Reset, ce_n=0, oe_n=0, mode ARRAY at word 5 -> `flash_data`=16'hFFFF; release oe_n -> bus Z.
- Driver `enable_write` addr 5, data 16'h1234 -> `dev_busy` high 8 cycles, driver polls SR until bit 7, driver reads word 5 -> 16'h1234; program 16'hFF00 over it -> 16'h1200.
- Program words 64 and 127, `enable_erase` addr 70 -> `dev_busy` high 64 cycles; words 64..127 read 16'hFFFF, word 5 unchanged.
- Write 16'h0020 then 16'h00FF (bad confirm) -> no erase, status read 16'h00B0; write 16'h0050 -> status 16'h0080.
- Assert rp_n=0 midway through erase -> `dev_busy`=0 next cycle, mode ARRAY, SR 16'h0080, earlier swept words FFFF, remaining words unchanged.
- Aliasing: program word addr 5 + 2^MEM_ADDR_WIDTH -> read of word 5 returns the programmed value.
